dcache_responder: RTL

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through/no-allocate data cache.
// The CPU is stalled while a refill or a write-through is in flight on the memory port.
`timescale 1ns/1ps
module dcache_responder #(
    parameter int unsigned LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_din,
    input  logic [3:0]  dcache_we,
    input  logic        dcache_re,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_REQ,
        RD_WAIT,
        WR_REQ
    } state_t;

    state_t state, state_nxt;

    logic [29:0]      addr_q;
    logic [31:0]      din_q;
    logic [3:0]       we_q;
    logic             re_q;
    logic [31:0]      dout_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      line_word;
    logic [31:0]      merged;
    logic             hit;
    logic             is_write;
    logic             is_read;
    logic             cpu_req;
    logic             capture;
    logic             read_hit;
    logic             refill;
    logic             wr_hit;

    // Byte offset bits never take part in lookup or the memory word address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dcache_addr[1:0];

    assign idx       = addr_q[IDX_W-1:0];
    assign tag       = addr_q[29:IDX_W];
    assign line_word = data_arr[idx];
    assign hit       = valid_q[idx] && (tag_arr[idx] == tag);
    assign is_write  = (we_q != 4'b0000);
    assign is_read   = re_q && !is_write;
    assign cpu_req   = dcache_re || (dcache_we != 4'b0000);

    assign mem_req_addr = addr_q;
    assign mem_req_data = din_q;
    assign mem_req_mask = we_q;
    assign dcache_dout  = read_hit ? line_word : dout_q;

    // Masked byte merge used for write hits.
    always_comb begin
        merged = line_word;
        for (int b = 0; b < 4; b++) begin
            if (we_q[b]) begin
                merged[8*b +: 8] = din_q[8*b +: 8];
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        capture       = 1'b0;
        read_hit      = 1'b0;
        refill        = 1'b0;
        wr_hit        = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    capture   = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (is_write) begin
                    stall     = 1'b1;
                    wr_hit    = hit;
                    state_nxt = WR_REQ;
                end else if (is_read && hit) begin
                    read_hit = 1'b1;
                    if (cpu_req) begin
                        capture   = 1'b1;
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (is_read) begin
                    stall     = 1'b1;
                    state_nxt = RD_REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    refill    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request capture, valid bits and returned data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= '0;
            re_q    <= 1'b0;
            dout_q  <= '0;
            valid_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q <= dcache_addr[31:2];
                din_q  <= dcache_din;
                we_q   <= dcache_we;
                re_q   <= dcache_re;
            end
            if (read_hit) begin
                dout_q <= line_word;
            end
            if (refill) begin
                dout_q       <= mem_resp_data;
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (refill) begin
            data_arr[idx] <= mem_resp_data;
            tag_arr[idx]  <= tag;
        end else if (wr_hit) begin
            data_arr[idx] <= merged;
        end
    end

endmodule
